mtr_drv: RTL and testbench
==========================

Name: mtr_drv

Overview:
- Consumer end of the balance-controller duty path. Takes the 11-bit unsigned `mtr_duty` magnitude and the `rev` direction flag that the duty computation block produces, and turns them into the two registered PWM lines of one motor H-bridge.
- Duty and direction are latched only at period boundaries, so a new command never glitches a period in progress.
- A direction reversal inserts a programmable dead interval to prevent shoot-through.
- Two instances sit between the duty/steer logic and the motor pins, one for the left motor and one for the right.

Parameters:
- CNT_W, 11, width of the PWM counter and duty input; period = 2^CNT_W clocks.
- DEAD_PERIODS, 1, number of whole PWM periods both outputs are held inactive on a direction change (1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  drive enable (power-up/rider-present); low forces outputs inactive.
- mtr_duty  input  CNT_W  unsigned duty magnitude; 0 = off, 2047 = 2047/2048 high.
- rev  input  1  requested direction; 1 = reverse.
- pwm_fwd  output  1  forward H-bridge drive, registered.
- pwm_rev  output  1  reverse H-bridge drive, registered.
- period_tick  output  1  one-cycle pulse on the last count of each period (cnt == 2^CNT_W-1), registered.
- dir_q  output  1  direction currently being driven (valid in FWD/REV), registered.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n low at a clk edge): the following all clear.
  - cnt = 0, duty_q = 0, dir_q = 0, dead_cnt = 0.
  - State = FWD.
  - pwm_fwd = 0, pwm_rev = 0, period_tick = 0.
- Counter: free-running, increments every clock and wraps 2^CNT_W-1 -> 0. It is held at 0 while en is low.
- Boundary sample: on the cycle cnt == 2^CNT_W-1 with en high, the block does three things.
  - period_tick is set for the next cycle.
  - duty_q <= mtr_duty.
  - The direction FSM evaluates rev. mtr_duty/rev are ignored on every other cycle.
- FSM states:
  - FWD, REV: drive the active side.
  - DEAD: both outputs inactive.
- FSM transitions at the boundary:
  - FWD with rev = 1, or REV with rev = 0 -> DEAD, with dead_cnt <= DEAD_PERIODS-1.
  - DEAD with dead_cnt != 0 -> dead_cnt decrements.
  - DEAD with dead_cnt == 0 -> FWD or REV per the rev sampled at this boundary, and dir_q updates.
  - Otherwise the state holds.
  - A rev that toggles back during DEAD still completes the full dead interval; it then enters the direction sampled at exit.
- Outputs, registered (one-cycle latency from the compare):
  - pwm_fwd <= en & (state == FWD) & (cnt < duty_q).
  - pwm_rev <= en & (state == REV) & (cnt < duty_q).
  - pwm_fwd and pwm_rev are never both 1 (assertion).
- Boundary cases:
  - duty_q = 0: output constantly low.
  - duty_q = 2047: output low for exactly 1 clock per period (at cnt = 2047).
  - Duty change mid-period: takes effect at the next period only.
- en low: on the next edge both outputs go 0 and cnt is cleared. State and duty_q are retained.
- en rising: counting restarts from 0. The first boundary sample occurs 2^CNT_W-1 clocks later; until then the retained duty_q applies.
- Reset mid-period: overrides everything, with outputs low on the following cycle.

Optional Feature:
- Macro MTR_DRV_BRAKE_EN controls what the outputs do while the bridge is not driving.
- Defined: in DEAD, and whenever duty_q == 0 with en high, both pwm_fwd and pwm_rev are driven 1 (low-side dynamic brake). The mutual-exclusion assertion is relaxed to "both high only in brake condition".
- Undefined: both outputs are 0 (coast) in those conditions.

Decomposition:
- Shared package (segway_pkg) holds:
  - The state enum {FWD, REV, DEAD}.
  - A localparam PWM_PERIOD = 2^CNT_W.
  - The duty width constant 11, shared with the duty computation block.
- One natural sub-module: pwm_cmp. It holds the counter, the boundary-latched duty_q and the registered compare output.
- mtr_drv instantiates pwm_cmp and wraps it with the direction FSM and output steering.

Test Plan:
- Steady forward: rev = 0, mtr_duty = 512, en = 1 -> pwm_fwd high 512 clocks per 2048-clock period, pwm_rev always 0, period_tick every 2048 clocks.
- Mid-period update: change mtr_duty 512 -> 1024 at cnt = 300 -> the current period still shows 512 high; the next period shows 1024.
- Reversal: rev 0 -> 1 with mtr_duty = 800, DEAD_PERIODS = 1 -> one full period with both outputs 0 (or both 1 with MTR_DRV_BRAKE_EN), then pwm_rev high 800 clocks/period; outputs never overlap.
- Extremes: mtr_duty = 0 -> output stays low; mtr_duty = 2047 -> output low exactly 1 clock per period.
- Enable drop: en low at cnt = 100 while driving -> outputs 0 on the next clock and cnt = 0. en high again -> first boundary sample occurs 2047 clocks after en rises.
- Reset mid-operation: rst_n low for 1 clock during REV at cnt = 900 -> next cycle all outputs 0, state FWD, duty_q 0.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared definitions for the balance-controller motor drive path.
package segway_pkg;

   // Duty magnitude width, shared with the duty computation block.
   localparam int DUTY_W = 11;

   // PWM period in clocks for the default counter width.
   localparam int PWM_PERIOD = 1 << DUTY_W;

   // Direction FSM states of one H-bridge driver.
   typedef enum logic [1:0] {
      FWD  = 2'd0,
      REV  = 2'd1,
      DEAD = 2'd2
   } mtr_state_e;

   // PWM period for an arbitrary counter width.
   function automatic int pwm_period(input int cnt_w);
      return 1 << cnt_w;
   endfunction

endpackage

// File: rtl/mtr_drv_chk.sv
// Shoot-through checker: both bridge lines may only be high together when
// the previous cycle was in a brake condition (never, in a coast build).
module mtr_drv_chk (
   input logic clk,
   input logic rst_n,
   input logic pwm_fwd_i,
   input logic pwm_rev_i,
   input logic brake_i
);

   a_no_overlap: assert property (
      @(posedge clk) disable iff (!rst_n)
         (pwm_fwd_i && pwm_rev_i) |-> $past(brake_i)
   );

endmodule

// File: rtl/mtr_drv_pwm_cmp.sv
// PWM counter, period-boundary duty latch and registered output compare.
// Outputs are steered by the direction selects from the parent FSM; the
// brake term drives both lines high when BRAKE_EN is set.
module pwm_cmp
   import segway_pkg::*;
#(
   parameter int CNT_W    = DUTY_W,
   parameter bit BRAKE_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [CNT_W-1:0] duty_i,
   input  logic             drv_fwd_i,
   input  logic             drv_rev_i,
   input  logic             dead_i,
   output logic             boundary_o,
   output logic             brake_o,
   output logic             pwm_fwd_o,
   output logic             pwm_rev_o,
   output logic             period_tick_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] duty_q;
   logic [CNT_W-1:0] duty_d;
   logic             pwm_fwd_q;
   logic             pwm_fwd_d;
   logic             pwm_rev_q;
   logic             pwm_rev_d;
   logic             period_tick_q;
   logic             below_s;
   logic             brake_s;

   // Next-state for counter, duty latch and steered compare outputs.
   always_comb begin
      boundary_o = en_i & (cnt_q == CNT_LAST);
      below_s    = (cnt_q < duty_q);
      brake_s    = BRAKE_EN & (dead_i | (duty_q == CNT_ZERO));
      brake_o    = en_i & brake_s;
      if (en_i) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = CNT_ZERO;
      end
      if (boundary_o) begin
         duty_d = duty_i;
      end else begin
         duty_d = duty_q;
      end
      pwm_fwd_d = en_i & ((drv_fwd_i & below_s) | brake_s);
      pwm_rev_d = en_i & ((drv_rev_i & below_s) | brake_s);
   end

   // Counter, duty and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q         <= CNT_ZERO;
         duty_q        <= CNT_ZERO;
         pwm_fwd_q     <= 1'b0;
         pwm_rev_q     <= 1'b0;
         period_tick_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         duty_q        <= duty_d;
         pwm_fwd_q     <= pwm_fwd_d;
         pwm_rev_q     <= pwm_rev_d;
         period_tick_q <= boundary_o;
      end
   end

   assign pwm_fwd_o     = pwm_fwd_q;
   assign pwm_rev_o     = pwm_rev_q;
   assign period_tick_o = period_tick_q;

endmodule

// File: rtl/mtr_drv.sv
// One motor H-bridge driver: boundary-latched duty PWM with a direction
// FSM that inserts whole dead periods on reversal.
// Optional macro MTR_DRV_BRAKE_EN: drive both lines high (dynamic brake)
// in DEAD and at zero duty instead of coasting.
module mtr_drv
   import segway_pkg::*;
#(
   parameter int CNT_W        = DUTY_W,
   parameter int DEAD_PERIODS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] mtr_duty,
   input  logic             rev,
   output logic             pwm_fwd,
   output logic             pwm_rev,
   output logic             period_tick,
   output logic             dir_q
);

`ifdef MTR_DRV_BRAKE_EN
   localparam bit BRAKE_EN = 1'b1;
`else
   localparam bit BRAKE_EN = 1'b0;
`endif

   localparam logic [3:0] DEAD_INIT = 4'(DEAD_PERIODS - 1);

   mtr_state_e state_q;
   logic [3:0] dead_cnt_q;
   logic       boundary_s;
   logic       brake_s;
   logic       drv_fwd_s;
   logic       drv_rev_s;
   logic       dead_s;

   // Decode the FSM state into output steering selects.
   always_comb begin
      drv_fwd_s = (state_q == FWD);
      drv_rev_s = (state_q == REV);
      dead_s    = (state_q == DEAD);
   end

   pwm_cmp #(
      .CNT_W    (CNT_W),
      .BRAKE_EN (BRAKE_EN)
   ) u_cmp (
      .clk           (clk),
      .rst_n         (rst_n),
      .en_i          (en),
      .duty_i        (mtr_duty),
      .drv_fwd_i     (drv_fwd_s),
      .drv_rev_i     (drv_rev_s),
      .dead_i        (dead_s),
      .boundary_o    (boundary_s),
      .brake_o       (brake_s),
      .pwm_fwd_o     (pwm_fwd),
      .pwm_rev_o     (pwm_rev),
      .period_tick_o (period_tick)
   );

   // Direction FSM: evaluates rev only at period boundaries.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FWD;
         dead_cnt_q <= 4'd0;
         dir_q      <= 1'b0;
      end else if (boundary_s) begin
         case (state_q)
            FWD: begin
               if (rev) begin
                  state_q    <= DEAD;
                  dead_cnt_q <= DEAD_INIT;
               end
            end
            REV: begin
               if (!rev) begin
                  state_q    <= DEAD;
                  dead_cnt_q <= DEAD_INIT;
               end
            end
            DEAD: begin
               if (dead_cnt_q != 4'd0) begin
                  dead_cnt_q <= dead_cnt_q - 4'd1;
               end else begin
                  state_q <= rev ? REV : FWD;
                  dir_q   <= rev;
               end
            end
            default: begin
               state_q    <= DEAD;
               dead_cnt_q <= DEAD_INIT;
            end
         endcase
      end
   end

   mtr_drv_chk u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_fwd_i (pwm_fwd),
      .pwm_rev_i (pwm_rev),
      .brake_i   (brake_s)
   );

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: directed scenarios plus random traffic,
// compared every cycle against a behavioural period/direction model.
module tb_mtr_drv;

   localparam int CNT_W  = 11;
   localparam int P      = 1 << CNT_W;
   localparam int DEAD_P = 1;

`ifdef MTR_DRV_BRAKE_EN
   localparam bit TB_BRAKE = 1'b1;
`else
   localparam bit TB_BRAKE = 1'b0;
`endif

   localparam int MD_FWD  = 0;
   localparam int MD_REV  = 1;
   localparam int MD_DEAD = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [CNT_W-1:0] mtr_duty;
   logic             rev;
   logic             pwm_fwd;
   logic             pwm_rev;
   logic             period_tick;
   logic             dir_q;

   mtr_drv #(
      .CNT_W        (CNT_W),
      .DEAD_PERIODS (DEAD_P)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mtr_duty    (mtr_duty),
      .rev         (rev),
      .pwm_fwd     (pwm_fwd),
      .pwm_rev     (pwm_rev),
      .period_tick (period_tick),
      .dir_q       (dir_q)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: position in period, latched duty, drive mode.
   int m_cnt  = 0;
   int m_duty = 0;
   int m_dir  = 0;
   int m_mode = MD_FWD;
   int m_dead = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock: predict outputs from the model, then compare.
   task automatic tick();
      bit ef, er, et, brk;
      ef = 1'b0; er = 1'b0; et = 1'b0;
      if (!rst_n) begin
         m_cnt = 0; m_duty = 0; m_dir = 0; m_mode = MD_FWD; m_dead = 0;
      end else begin
         brk = TB_BRAKE && (m_mode == MD_DEAD || m_duty == 0);
         ef  = en && ((m_mode == MD_FWD && m_cnt < m_duty) || brk);
         er  = en && ((m_mode == MD_REV && m_cnt < m_duty) || brk);
         et  = en && (m_cnt == P - 1);
         if (et) begin
            m_duty = int'(mtr_duty);
            if (m_mode == MD_DEAD) begin
               if (m_dead > 0) m_dead--;
               else begin
                  m_mode = rev ? MD_REV : MD_FWD;
                  m_dir  = int'(rev);
               end
            end else if ((m_mode == MD_FWD && rev) || (m_mode == MD_REV && !rev)) begin
               m_mode = MD_DEAD;
               m_dead = DEAD_P - 1;
            end
         end
         m_cnt = en ? (m_cnt + 1) % P : 0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("cycle_out", {28'd0, pwm_fwd, pwm_rev, period_tick, dir_q},
          {28'd0, ef, er, et, m_dir[0]});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_cnt(input int target);
      int guard;
      guard = 0;
      while (m_cnt != target && guard < 3 * P) begin
         tick();
         guard++;
      end
      if (m_cnt != target) chk("wait_timeout", 32'(m_cnt), 32'(target));
   endtask

   // Count high samples over one full aligned period (cnt 0..P-1 compares).
   task automatic measure(input int chg_at, input int chg_val,
                          output int hf, output int hr, output int tk, output int ov);
      wait_cnt(1);
      hf = int'(pwm_fwd); hr = int'(pwm_rev); tk = int'(period_tick);
      ov = int'(pwm_fwd & pwm_rev);
      for (int i = 1; i < P; i++) begin
         if (m_cnt == chg_at) mtr_duty = CNT_W'(chg_val);
         tick();
         hf += int'(pwm_fwd); hr += int'(pwm_rev); tk += int'(period_tick);
         ov += int'(pwm_fwd & pwm_rev);
      end
   endtask

   initial begin
      int hf, hr, tk, ov, n;
      rst_n = 1'b0; en = 1'b0; mtr_duty = '0; rev = 1'b0;
      run(3);
      chk("reset_state", {28'd0, pwm_fwd, pwm_rev, period_tick, dir_q}, 32'd0);

      // Steady forward at 512.
      rst_n = 1'b1; en = 1'b1; mtr_duty = 11'd512;
      run(P + 10);
      measure(-1, 0, hf, hr, tk, ov);
      chk("fwd512_hi", 32'(hf), 32'd512);
      chk("fwd512_rev", 32'(hr), 32'd0);
      chk("fwd512_tick", 32'(tk), 32'd1);

      // Mid-period change only affects the next period.
      measure(300, 1024, hf, hr, tk, ov);
      chk("mid_cur", 32'(hf), 32'd512);
      measure(-1, 0, hf, hr, tk, ov);
      chk("mid_next", 32'(hf), 32'd1024);

      // Extremes.
      mtr_duty = 11'd0;
      measure(-1, 0, hf, hr, tk, ov);
      measure(-1, 0, hf, hr, tk, ov);
      chk("duty0_fwd", 32'(hf), TB_BRAKE ? 32'(P) : 32'd0);
      chk("duty0_rev", 32'(hr), TB_BRAKE ? 32'(P) : 32'd0);
      mtr_duty = 11'd2047;
      measure(-1, 0, hf, hr, tk, ov);
      measure(-1, 0, hf, hr, tk, ov);
      chk("duty_max_fwd", 32'(hf), 32'(P - 1));

      // Reversal through one dead period.
      mtr_duty = 11'd800; rev = 1'b1;
      measure(-1, 0, hf, hr, tk, ov);
      measure(-1, 0, hf, hr, tk, ov);
      chk("dead_fwd", 32'(hf), TB_BRAKE ? 32'(P) : 32'd0);
      chk("dead_rev", 32'(hr), TB_BRAKE ? 32'(P) : 32'd0);
      measure(-1, 0, hf, hr, tk, ov);
      chk("rev_hi", 32'(hr), 32'd800);
      chk("rev_fwd", 32'(hf), 32'd0);
      chk("rev_overlap", 32'(ov), 32'd0);
      chk("rev_dir", {31'd0, dir_q}, 32'd1);

      // Enable drop and restart latency.
      wait_cnt(100);
      en = 1'b0;
      tick();
      chk("en_off_out", {30'd0, pwm_fwd, pwm_rev}, 32'd0);
      chk("en_off_cnt", 32'(dut.u_cmp.cnt_q), 32'd0);
      run(40);
      mtr_duty = 11'd300;
      en = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!period_tick && n < 3 * P);
      chk("en_tick_lat", 32'(n), 32'(P));

      // Reset during REV.
      wait_cnt(900);
      rst_n = 1'b0;
      tick();
      chk("rst_mid_out", {28'd0, pwm_fwd, pwm_rev, period_tick, dir_q}, 32'd0);
      chk("rst_mid_duty", 32'(dut.u_cmp.duty_q), 32'd0);
      rst_n = 1'b1;

      // Random traffic.
      for (int i = 0; i < 8 * P; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            case ($urandom_range(0, 3))
               0:       mtr_duty = 11'd0;
               1:       mtr_duty = 11'd2047;
               default: mtr_duty = CNT_W'($urandom_range(0, P - 1));
            endcase
         end
         if ($urandom_range(0, 1499) == 0) rev = ~rev;
         if (en && $urandom_range(0, 3999) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
